bfm_arbiter: RTL and testbench
==============================

Name: bfm_arbiter

Overview:
- Self-checking bus-functional model around a 5-port round-robin arbiter for the NoC router.
- Decodes a 6-bit command into one or two request phases and drives the embedded arbiter.
- Checks each arbiter grant against the expected winner.
- Pulses bfm_grant when the command completes, which is the handshake for the next command.

Parameters:
- NPORTS, 5, number of arbitrated ports. Fixed order: bit0=L (Local), bit1=N, bit2=E, bit3=S, bit4=W.

Ports:
- bfm_clk  input  1  sole clock; all logic on its rising edge.
- bfm_rst  input  1  reset, synchronous, active-high.
- bfm_command  input  6  command code; sampled in IDLE only.
- bfm_grant  output  1  one-cycle pulse marking command completion.
- arb_req  output  5  request vector currently driven into the arbiter.
- arb_grant  output  5  registered one-hot arbiter grant.
- bfm_error  output  1  sticky mismatch or illegal-command flag.

Behaviour:
- Reset (bfm_rst=1 at an edge), also when asserted mid-command:
  - FSM goes to IDLE.
  - bfm_grant=0, arb_req=0, arb_grant=0, bfm_error=0.
  - Arbiter last-served pointer = W, so L has top priority.
- Arbiter:
  - Each edge: arb_grant <= one-hot of the first set arb_req bit, searching cyclically from (last_served+1) mod 5.
  - If any bit is granted, last_served <= that port.
  - If arb_req=0: arb_grant <= 0 and the pointer is unchanged.
  - At most one grant bit is ever set.
- Command map (X,Y,Z ∈ {L,N,E,S,W}):
  - 1 NOREQ1 and 7 NOREQ2: one phase, empty request, expect grant 0.
  - 2..6 REQFL, REQFN, REQFE, REQFW, REQFS: one phase, single request.
  - 8..32 REQFXY: phase1 request X alone, phase2 request Y alone. Codes:
    - 8..12 LN, LE, LW, LS, LL
    - 13..17 NE, NW, NS, NL, NN
    - 18..22 EW, ES, EL, EN, EE
    - 23..27 WS, WL, WN, WE, WW
    - 28..32 SL, SN, SE, SW, SS
  - 33..62 REQFXY_Z: phase1 request Z alone (sets last-served), phase2 requests X and Y simultaneously. Codes:
    - 33..38 NE, NW, NS, EW, ES, WS with Z=L
    - 39..44 LE, LW, LS, EW, ES, WS with Z=N
    - 45..50 LN, LW, LS, NW, NS, WS with Z=E
    - 51..56 LN, LE, LS, NE, NS, ES with Z=W
    - 57..62 LN, LE, LW, NE, NW, EW with Z=S
  - 0 and 63 are illegal: set bfm_error, run as NOREQ.
- FSM: IDLE -> P1 -> C1 -> [P2 -> C2] -> DONE -> IDLE.
  - IDLE: latch bfm_command at the edge; move to P1.
  - P1/P2: arb_req = phase vector for exactly one cycle.
  - C1/C2: arb_req=0; arb_grant holds the registered result and is compared with the expected one-hot (round-robin from the model's own pointer copy). Any mismatch sets bfm_error.
  - DONE: bfm_grant=1 for exactly one cycle.
- Latency from the latching edge to bfm_grant high:
  - 3 cycles for one-phase commands (P1, C1, DONE).
  - 5 cycles for two-phase commands.
- bfm_command may change any time after bfm_grant rises. The value present at the IDLE edge is the one used.
- A repeated identical command is re-executed.
- The arbiter pointer persists across commands; only reset reinitializes it.
- bfm_error stays set until reset.

Test Plan:
- Reset, then REQFL(2) -> arb_req=00001 for one cycle, arb_grant=00001 next cycle, bfm_grant pulses 3 cycles after latching, bfm_error=0.
- After reset, REQFNE_L(33) -> phase1 grant 00001, phase2 req 00110 -> grant 00010 (N), bfm_error=0.
- REQFLN_E(45) -> phase1 grant 00100, phase2 req 00011 -> grant 00001 (L, wrap-around past S,W), bfm_grant 5 cycles after latching.
- REQFNW_S(61) -> grant W (10000). Then REQFLL(12) -> two grants 00001, bfm_error=0.
- bfm_command=0 -> bfm_error=1, arb_grant stays 0, bfm_grant still pulses. Then bfm_rst -> bfm_error=0.
- Assert bfm_rst during C2 of REQFWS(23) -> next cycle IDLE, arb_req=0, arb_grant=0, no bfm_grant pulse. Then REQFE(4) -> grant 00100.

Source files
------------

// File: rtl/bfm_arbiter_if.sv
// Command/response and arbiter-observation bundle for bfm_arbiter.
// The slave side is the BFM itself; the master side is whoever issues commands.
interface bfm_arbiter_if #(
  parameter int NPORTS = 5
);
  logic [5:0]        bfm_command;
  logic              bfm_grant;
  logic [NPORTS-1:0] arb_req;
  logic [NPORTS-1:0] arb_grant;
  logic              bfm_error;

  modport master (
    output bfm_command,
    input  bfm_grant,
    input  arb_req,
    input  arb_grant,
    input  bfm_error
  );

  modport slave (
    input  bfm_command,
    output bfm_grant,
    output arb_req,
    output arb_grant,
    output bfm_error
  );
endinterface

// File: rtl/bfm_arbiter.sv
// Bus-functional model wrapped around a 5-port round-robin arbiter.
// A 6-bit command is decoded into one or two request phases, each phase is
// driven into the arbiter for a single cycle, and the registered grant is
// compared against a private reference copy of the round-robin pointer.
// Port order: bit0=L, bit1=N, bit2=E, bit3=S, bit4=W.
module bfm_arbiter #(
  parameter int NPORTS = 5
) (
  input  logic         bfm_clk,
  input  logic         bfm_rst,
  bfm_arbiter_if.slave bus
);

  localparam logic [NPORTS-1:0] P_L = 5'b00001;
  localparam logic [NPORTS-1:0] P_N = 5'b00010;
  localparam logic [NPORTS-1:0] P_E = 5'b00100;
  localparam logic [NPORTS-1:0] P_S = 5'b01000;
  localparam logic [NPORTS-1:0] P_W = 5'b10000;
  // After reset the pointer sits on W so that L is searched first.
  localparam logic [2:0]        PTR_RESET = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_C1,
    S_P2,
    S_C2,
    S_DONE
  } state_t;

  typedef struct packed {
    logic              two;
    logic [NPORTS-1:0] ph1;
    logic [NPORTS-1:0] ph2;
  } dec_t;

  // One-phase command: request vector a, no second phase.
  function automatic dec_t mk1(input logic [NPORTS-1:0] a);
    dec_t d;
    d.two = 1'b0;
    d.ph1 = a;
    d.ph2 = '0;
    return d;
  endfunction

  // Two-phase command: request vector a, then request vector b.
  function automatic dec_t mk2(input logic [NPORTS-1:0] a,
                               input logic [NPORTS-1:0] b);
    dec_t d;
    d.two = 1'b1;
    d.ph1 = a;
    d.ph2 = b;
    return d;
  endfunction

  // Codes 0 and 63 are not part of the command map.
  function automatic logic is_illegal(input logic [5:0] cmd);
    return (cmd == 6'd0) || (cmd == 6'd63);
  endfunction

  // Command map. Illegal and NOREQ codes both decode to an empty single phase.
  function automatic dec_t decode(input logic [5:0] cmd);
    dec_t d;
    d = mk1('0);
    case (cmd)
      // single requests
      6'd2:  d = mk1(P_L);
      6'd3:  d = mk1(P_N);
      6'd4:  d = mk1(P_E);
      6'd5:  d = mk1(P_W);
      6'd6:  d = mk1(P_S);
      // X alone, then Y alone
      6'd8:  d = mk2(P_L, P_N);
      6'd9:  d = mk2(P_L, P_E);
      6'd10: d = mk2(P_L, P_W);
      6'd11: d = mk2(P_L, P_S);
      6'd12: d = mk2(P_L, P_L);
      6'd13: d = mk2(P_N, P_E);
      6'd14: d = mk2(P_N, P_W);
      6'd15: d = mk2(P_N, P_S);
      6'd16: d = mk2(P_N, P_L);
      6'd17: d = mk2(P_N, P_N);
      6'd18: d = mk2(P_E, P_W);
      6'd19: d = mk2(P_E, P_S);
      6'd20: d = mk2(P_E, P_L);
      6'd21: d = mk2(P_E, P_N);
      6'd22: d = mk2(P_E, P_E);
      6'd23: d = mk2(P_W, P_S);
      6'd24: d = mk2(P_W, P_L);
      6'd25: d = mk2(P_W, P_N);
      6'd26: d = mk2(P_W, P_E);
      6'd27: d = mk2(P_W, P_W);
      6'd28: d = mk2(P_S, P_L);
      6'd29: d = mk2(P_S, P_N);
      6'd30: d = mk2(P_S, P_E);
      6'd31: d = mk2(P_S, P_W);
      6'd32: d = mk2(P_S, P_S);
      // Z alone to position the pointer, then X and Y together
      6'd33: d = mk2(P_L, P_N | P_E);
      6'd34: d = mk2(P_L, P_N | P_W);
      6'd35: d = mk2(P_L, P_N | P_S);
      6'd36: d = mk2(P_L, P_E | P_W);
      6'd37: d = mk2(P_L, P_E | P_S);
      6'd38: d = mk2(P_L, P_W | P_S);
      6'd39: d = mk2(P_N, P_L | P_E);
      6'd40: d = mk2(P_N, P_L | P_W);
      6'd41: d = mk2(P_N, P_L | P_S);
      6'd42: d = mk2(P_N, P_E | P_W);
      6'd43: d = mk2(P_N, P_E | P_S);
      6'd44: d = mk2(P_N, P_W | P_S);
      6'd45: d = mk2(P_E, P_L | P_N);
      6'd46: d = mk2(P_E, P_L | P_W);
      6'd47: d = mk2(P_E, P_L | P_S);
      6'd48: d = mk2(P_E, P_N | P_W);
      6'd49: d = mk2(P_E, P_N | P_S);
      6'd50: d = mk2(P_E, P_W | P_S);
      6'd51: d = mk2(P_W, P_L | P_N);
      6'd52: d = mk2(P_W, P_L | P_E);
      6'd53: d = mk2(P_W, P_L | P_S);
      6'd54: d = mk2(P_W, P_N | P_E);
      6'd55: d = mk2(P_W, P_N | P_S);
      6'd56: d = mk2(P_W, P_E | P_S);
      6'd57: d = mk2(P_S, P_L | P_N);
      6'd58: d = mk2(P_S, P_L | P_E);
      6'd59: d = mk2(P_S, P_L | P_W);
      6'd60: d = mk2(P_S, P_N | P_E);
      6'd61: d = mk2(P_S, P_N | P_W);
      6'd62: d = mk2(P_S, P_E | P_W);
      default: d = mk1('0);
    endcase
    return d;
  endfunction

  // Round-robin pick: first set request bit searching cyclically from last+1.
  function automatic logic [NPORTS-1:0] rr_grant(input logic [NPORTS-1:0] req,
                                                 input logic [2:0]        last);
    logic [NPORTS-1:0] g;
    logic              found;
    int                s;
    logic [2:0]        p;
    g     = '0;
    found = 1'b0;
    for (int i = 1; i <= NPORTS; i++) begin
      s = int'(last) + i;
      if (s >= NPORTS) s = s - NPORTS;
      p = s[2:0];
      if (!found && req[p]) begin
        g[p]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  // Index of the set bit of a one-hot grant (0 when empty).
  function automatic logic [2:0] oh2idx(input logic [NPORTS-1:0] g);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < NPORTS; i++) begin
      if (g[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  state_t            r_state;
  state_t            w_next;
  dec_t              r_dec;
  dec_t              w_in_dec;
  logic [NPORTS-1:0] w_req;
  logic              w_bfm_grant;
  logic              w_latch;
  logic              w_phase;
  logic              w_check;

  logic [NPORTS-1:0] r_grant;
  logic [2:0]        r_last;
  logic [NPORTS-1:0] w_arb_grant;

  logic [2:0]        r_mdl_last;
  logic [NPORTS-1:0] r_exp;
  logic [NPORTS-1:0] w_mdl_grant;
  logic              r_error;

  assign w_in_dec    = decode(bus.bfm_command);
  assign w_arb_grant = rr_grant(w_req, r_last);
  assign w_mdl_grant = rr_grant(w_req, r_mdl_last);

  // FSM state register.
  always_ff @(posedge bfm_clk) begin
    if (bfm_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next state and per-state strobes; requests live for exactly one cycle.
  always_comb begin
    w_next      = r_state;
    w_req       = '0;
    w_bfm_grant = 1'b0;
    w_latch     = 1'b0;
    w_phase     = 1'b0;
    w_check     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_latch = 1'b1;
        w_next  = S_P1;
      end
      S_P1: begin
        w_req   = r_dec.ph1;
        w_phase = 1'b1;
        w_next  = S_C1;
      end
      S_C1: begin
        w_check = 1'b1;
        w_next  = r_dec.two ? S_P2 : S_DONE;
      end
      S_P2: begin
        w_req   = r_dec.ph2;
        w_phase = 1'b1;
        w_next  = S_C2;
      end
      S_C2: begin
        w_check = 1'b1;
        w_next  = S_DONE;
      end
      S_DONE: begin
        w_bfm_grant = 1'b1;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Capture the decoded command at the IDLE edge; it is only read after that.
  always_ff @(posedge bfm_clk) begin
    if (w_latch) r_dec <= w_in_dec;
  end

  // Embedded arbiter: registered one-hot grant and last-served pointer.
  always_ff @(posedge bfm_clk) begin
    if (bfm_rst) begin
      r_grant <= '0;
      r_last  <= PTR_RESET;
    end else begin
      r_grant <= w_arb_grant;
      if (|w_arb_grant) r_last <= oh2idx(w_arb_grant);
    end
  end

  // Reference pointer copy: predicts the grant for each request phase.
  always_ff @(posedge bfm_clk) begin
    if (bfm_rst) begin
      r_mdl_last <= PTR_RESET;
      r_exp      <= '0;
    end else if (w_phase) begin
      r_exp <= w_mdl_grant;
      if (|w_mdl_grant) r_mdl_last <= oh2idx(w_mdl_grant);
    end
  end

  // Sticky error: illegal command at latch time or grant mismatch in a check state.
  always_ff @(posedge bfm_clk) begin
    if (bfm_rst) begin
      r_error <= 1'b0;
    end else if (w_latch && is_illegal(bus.bfm_command)) begin
      r_error <= 1'b1;
    end else if (w_check && (r_grant != r_exp)) begin
      r_error <= 1'b1;
    end
  end

  assign bus.bfm_grant = w_bfm_grant;
  assign bus.arb_req   = w_req;
  assign bus.arb_grant = r_grant;
  assign bus.bfm_error = r_error;

endmodule

// File: tb/tb_bfm_arbiter.sv
// Directed bench for bfm_arbiter: each command is walked cycle by cycle
// (IDLE latch -> P1 -> C1 -> [P2 -> C2] -> DONE) against hand-computed
// request vectors, grants, completion pulse and error flag.
module tb_bfm_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bfm_arbiter_if bus ();

  bfm_arbiter dut (
    .bfm_clk (clk),
    .bfm_rst (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one command starting from IDLE; ends back in IDLE with NOREQ1 queued.
  task automatic run_cmd(input logic [5:0] cmd, input bit two,
                         input logic [4:0] ph1, input logic [4:0] g1,
                         input logic [4:0] ph2, input logic [4:0] g2,
                         input bit exp_err, input string name);
    bus.bfm_command = cmd;
    tick;  // latching edge -> P1
    checks++;
    if (bus.arb_req !== ph1 || bus.arb_grant !== 5'b0 || bus.bfm_grant !== 1'b0) begin
      errors++;
      $display("FAIL %s P1 req=%b grant=%b bfm_grant=%b want req=%b grant=00000 bfm_grant=0",
               name, bus.arb_req, bus.arb_grant, bus.bfm_grant, ph1);
    end
    tick;  // C1
    checks++;
    if (bus.arb_req !== 5'b0 || bus.arb_grant !== g1 || bus.bfm_grant !== 1'b0) begin
      errors++;
      $display("FAIL %s C1 req=%b grant=%b bfm_grant=%b want req=00000 grant=%b bfm_grant=0",
               name, bus.arb_req, bus.arb_grant, bus.bfm_grant, g1);
    end
    if (two) begin
      tick;  // P2
      checks++;
      if (bus.arb_req !== ph2 || bus.arb_grant !== 5'b0 || bus.bfm_grant !== 1'b0) begin
        errors++;
        $display("FAIL %s P2 req=%b grant=%b bfm_grant=%b want req=%b grant=00000 bfm_grant=0",
                 name, bus.arb_req, bus.arb_grant, bus.bfm_grant, ph2);
      end
      tick;  // C2
      checks++;
      if (bus.arb_req !== 5'b0 || bus.arb_grant !== g2 || bus.bfm_grant !== 1'b0) begin
        errors++;
        $display("FAIL %s C2 req=%b grant=%b bfm_grant=%b want req=00000 grant=%b bfm_grant=0",
                 name, bus.arb_req, bus.arb_grant, bus.bfm_grant, g2);
      end
    end
    tick;  // DONE: 3rd cycle after latching (one phase) or 5th (two phases)
    checks++;
    if (bus.bfm_grant !== 1'b1 || bus.bfm_error !== exp_err || bus.arb_req !== 5'b0) begin
      errors++;
      $display("FAIL %s DONE bfm_grant=%b err=%b req=%b want bfm_grant=1 err=%b req=00000",
               name, bus.bfm_grant, bus.bfm_error, bus.arb_req, exp_err);
    end
    bus.bfm_command = 6'd1;
    tick;  // IDLE
    checks++;
    if (bus.bfm_grant !== 1'b0 || bus.arb_req !== 5'b0) begin
      errors++;
      $display("FAIL %s IDLE bfm_grant=%b req=%b want bfm_grant=0 req=00000",
               name, bus.bfm_grant, bus.arb_req);
    end
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    bus.bfm_command = 6'd1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.bfm_command = 6'd1;
    tick;
    tick;
    checks++;
    if (bus.bfm_grant !== 1'b0 || bus.arb_req !== 5'b0 ||
        bus.arb_grant !== 5'b0 || bus.bfm_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_state bfm_grant=%b req=%b grant=%b err=%b want all zero",
               bus.bfm_grant, bus.arb_req, bus.arb_grant, bus.bfm_error);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_req;
    run_cmd(6'd2, 1'b0, 5'b00001, 5'b00001, 5'b0, 5'b0, 1'b0, "REQFL");
  endtask

  task automatic test_pair_z;
    apply_reset;
    run_cmd(6'd33, 1'b1, 5'b00001, 5'b00001, 5'b00110, 5'b00010, 1'b0, "REQFNE_L");
    run_cmd(6'd45, 1'b1, 5'b00100, 5'b00100, 5'b00011, 5'b00001, 1'b0, "REQFLN_E");
  endtask

  task automatic test_back_to_back;
    run_cmd(6'd61, 1'b1, 5'b01000, 5'b01000, 5'b10010, 5'b10000, 1'b0, "REQFNW_S");
    run_cmd(6'd12, 1'b1, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 1'b0, "REQFLL");
    run_cmd(6'd3,  1'b0, 5'b00010, 5'b00010, 5'b0, 5'b0, 1'b0, "REQFN_a");
    run_cmd(6'd3,  1'b0, 5'b00010, 5'b00010, 5'b0, 5'b0, 1'b0, "REQFN_b");
    run_cmd(6'd29, 1'b1, 5'b01000, 5'b01000, 5'b00010, 5'b00010, 1'b0, "REQFSN");
    run_cmd(6'd5,  1'b0, 5'b10000, 5'b10000, 5'b0, 5'b0, 1'b0, "REQFW");
    run_cmd(6'd6,  1'b0, 5'b01000, 5'b01000, 5'b0, 5'b0, 1'b0, "REQFS");
    run_cmd(6'd7,  1'b0, 5'b00000, 5'b00000, 5'b0, 5'b0, 1'b0, "NOREQ2");
  endtask

  task automatic test_illegal;
    run_cmd(6'd0,  1'b0, 5'b00000, 5'b00000, 5'b0, 5'b0, 1'b1, "ILLEGAL0");
    run_cmd(6'd63, 1'b0, 5'b00000, 5'b00000, 5'b0, 5'b0, 1'b1, "ILLEGAL63");
    run_cmd(6'd2,  1'b0, 5'b00001, 5'b00001, 5'b0, 5'b0, 1'b1, "sticky_REQFL");
    rst = 1'b1;
    tick;
    checks++;
    if (bus.bfm_error !== 1'b0 || bus.arb_grant !== 5'b0) begin
      errors++;
      $display("FAIL error_clear err=%b grant=%b want err=0 grant=00000",
               bus.bfm_error, bus.arb_grant);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid;
    apply_reset;
    bus.bfm_command = 6'd23;
    tick;  // P1
    tick;  // C1
    checks++;
    if (bus.arb_grant !== 5'b10000) begin
      errors++;
      $display("FAIL mid_C1 grant=%b want 10000", bus.arb_grant);
    end
    bus.bfm_command = 6'd1;
    tick;  // P2
    checks++;
    if (bus.arb_req !== 5'b01000) begin
      errors++;
      $display("FAIL mid_P2 req=%b want 01000", bus.arb_req);
    end
    tick;  // C2
    checks++;
    if (bus.arb_grant !== 5'b01000) begin
      errors++;
      $display("FAIL mid_C2 grant=%b want 01000", bus.arb_grant);
    end
    rst = 1'b1;
    tick;  // would have been DONE
    checks++;
    if (bus.bfm_grant !== 1'b0 || bus.arb_req !== 5'b0 || bus.arb_grant !== 5'b0) begin
      errors++;
      $display("FAIL mid_reset bfm_grant=%b req=%b grant=%b want 0/00000/00000",
               bus.bfm_grant, bus.arb_req, bus.arb_grant);
    end
    tick;
    checks++;
    if (bus.bfm_grant !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_hold bfm_grant=%b want 0", bus.bfm_grant);
    end
    rst = 1'b0;
    run_cmd(6'd4, 1'b0, 5'b00100, 5'b00100, 5'b0, 5'b0, 1'b0, "REQFE_after_reset");
  endtask

  initial begin
    bus.bfm_command = 6'd1;
    test_reset;
    test_single_req;
    test_pair_z;
    test_back_to_back;
    test_illegal;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
